ps2_rx_fifo: RTL and testbench



---
 rtl/ps2_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/ps2_rx_fifo.sv | 258 +++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 receiver and its event FIFO.
package ps2_pkg;

  // Prefix bytes that modify the following scan code.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Start bit, 8 data bits, parity, stop bit.
  localparam int PS2_FRAME_LEN = 11;

  // Output modes.
  localparam int MODE_RAW   = 0;
  localparam int MODE_EVENT = 1;

  // One FIFO entry.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Framer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy output.
// A push into a full FIFO is accepted only when a pop happens in the same clock.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Storage write; contents need no reset because empty entries are never shown.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, frame and check packets,
// optionally fold E0/F0 prefixes, and queue results for the key mapper.
//
// Consumer handshake: an entry transfers on any clk edge where ev_valid and
// ev_ready are both high; ev_code/ev_ext/ev_brk hold the head entry stable
// while ev_valid is high and ev_ready is low, and ev_ready with ev_valid low
// has no effect.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_DIV  = 250,
  parameter int FILT_LEN = 3,
  parameter int TIMEOUT  = 4000,
  parameter int DEPTH    = 8,
  parameter int MODE     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_dat,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_brk,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic                     frame_err,
  output logic [7:0]               err_cnt,
  output logic                     ovf,
  input  logic                     clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               dbg_state
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [3:0]    FILT_LAST = 4'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(PS2_FRAME_LEN - 1);
  localparam logic          EV_MODE   = (MODE == MODE_EVENT);

  logic [DW-1:0] r_div;
  logic          w_tick;
  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_clk_f;
  logic          r_dat_f;
  logic [3:0]    r_clk_cnt;
  logic [3:0]    r_dat_cnt;
  logic          r_clk_f_d;
  logic          w_fall;

  ps2_state_t    r_state;
  ps2_state_t    w_state_nxt;
  logic [10:0]   r_shift;
  logic [3:0]    r_bitcnt;
  logic [TW-1:0] r_to_cnt;
  logic          w_frame_ok;
  logic [7:0]    w_byte;

  logic          r_ext;
  logic          r_brk;
  logic          r_push;
  ps2_event_t    r_push_data;
  logic          r_ferr;

  ps2_event_t    w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;

  // Sample tick: one clk high every CLK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_div <= '0;
    else     r_div <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
  end
  assign w_tick = (r_div == DIV_LAST);

  // Two-flop synchronisers for both asynchronous pins; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_clk};
      r_dat_s <= {r_dat_s[0], ps2_dat};
    end
  end

  // Clock-line filter: change only after FILT_LEN consecutive differing ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_f   <= 1'b1;
      r_clk_cnt <= '0;
    end else if (w_tick) begin
      if (r_clk_s[1] == r_clk_f) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FILT_LAST) begin
        r_clk_f   <= r_clk_s[1];
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 4'd1;
      end
    end
  end

  // Data-line filter, same rule as the clock line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dat_f   <= 1'b1;
      r_dat_cnt <= '0;
    end else if (w_tick) begin
      if (r_dat_s[1] == r_dat_f) begin
        r_dat_cnt <= '0;
      end else if (r_dat_cnt == FILT_LAST) begin
        r_dat_f   <= r_dat_s[1];
        r_dat_cnt <= '0;
      end else begin
        r_dat_cnt <= r_dat_cnt + 4'd1;
      end
    end
  end

  // Delayed filtered clock for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_clk_f_d <= 1'b1;
    else     r_clk_f_d <= r_clk_f;
  end
  assign w_fall = r_clk_f_d & ~r_clk_f;

  // Framer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Framer next-state: shift on falling edges, check after 11 bits, abandon on timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_fall) begin
          w_state_nxt = (r_bitcnt == BIT_LAST) ? ST_CHECK : ST_SHIFT;
        end else if (w_tick && (r_to_cnt == TO_LAST)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, bit count and inactivity timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_to_cnt <= '0;
    end else begin
      if (r_state == ST_CHECK) begin
        r_bitcnt <= '0;
        r_to_cnt <= '0;
      end else if (w_fall) begin
        r_shift  <= {r_dat_f, r_shift[10:1]};
        r_bitcnt <= r_bitcnt + 4'd1;
        r_to_cnt <= '0;
      end else if ((r_state == ST_SHIFT) && w_tick) begin
        if (r_to_cnt == TO_LAST) begin
          r_bitcnt <= '0;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
      end
    end
  end

  // Frame is good with start=0, stop=1 and odd parity over data plus parity bit.
  assign w_byte     = r_shift[8:1];
  assign w_frame_ok = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);

  // Prefix folding and push staging; the push lands in the clk after CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_ferr      <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_ferr <= 1'b0;
      if (r_state == ST_CHECK) begin
        if (!w_frame_ok) begin
          r_ferr <= 1'b1;
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end else if (EV_MODE && (w_byte == PS2_EXT)) begin
          r_ext <= 1'b1;
        end else if (EV_MODE && (w_byte == PS2_BRK)) begin
          r_brk <= 1'b1;
        end else begin
          r_push           <= 1'b1;
          r_push_data.ext  <= EV_MODE & r_ext;
          r_push_data.brk  <= EV_MODE & r_brk;
          r_push_data.code <= w_byte;
          r_ext            <= 1'b0;
          r_brk            <= 1'b0;
        end
      end
    end
  end

  // Error counter and sticky overflow; clr takes priority over both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      err_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if ((r_state == ST_CHECK) && !w_frame_ok && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (r_push && w_full && !w_pop) ovf <= 1'b1;
    end
  end

  assign w_pop = ev_ready & ~w_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_din   (r_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign ev_valid  = ~w_empty;
  assign ev_code   = w_empty ? 8'h00 : w_head.code;
  assign ev_ext    = ~w_empty & w_head.ext;
  assign ev_brk    = ~w_empty & w_head.brk;
  assign frame_err = r_ferr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: one event-mode and one raw-mode instance on
// the same PS/2 lines, with hand-computed expected scan codes.
module tb_ps2_rx_fifo;

  localparam int CLK_DIV  = 4;
  localparam int FILT_LEN = 2;
  localparam int TIMEOUT  = 100;
  localparam int DEPTH    = 4;
  localparam int HALF_BIT = 10 * CLK_DIV;  // 10 ticks per clock phase, 20 per bit

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_dat, clr;
  logic ready1, ready0;

  always #5 clk = ~clk;

  logic [7:0] e1_code, e0_code, e1_err, e0_err;
  logic       e1_ext, e1_brk, e1_valid, e1_ferr, e1_ovf;
  logic       e0_ext, e0_brk, e0_valid, e0_ferr, e0_ovf;
  logic [2:0] e1_level, e0_level;
  logic [1:0] e1_state, e0_state;

  ps2_rx_fifo #(.CLK_DIV(CLK_DIV), .FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT),
                .DEPTH(DEPTH), .MODE(1)) u_ev (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .ev_code(e1_code), .ev_ext(e1_ext), .ev_brk(e1_brk), .ev_valid(e1_valid),
    .ev_ready(ready1), .frame_err(e1_ferr), .err_cnt(e1_err), .ovf(e1_ovf),
    .clr(clr), .level(e1_level), .dbg_state(e1_state)
  );

  ps2_rx_fifo #(.CLK_DIV(CLK_DIV), .FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT),
                .DEPTH(DEPTH), .MODE(0)) u_raw (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .ev_code(e0_code), .ev_ext(e0_ext), .ev_brk(e0_brk), .ev_valid(e0_valid),
    .ev_ready(ready0), .frame_err(e0_ferr), .err_cnt(e0_err), .ovf(e0_ovf),
    .clr(clr), .level(e0_level), .dbg_state(e0_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_ferr   = 0;
  logic [7:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count frame_err pulses of the event-mode instance, sampled away from the edge.
  always @(negedge clk) if (e1_ferr === 1'b1) n_ferr++;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; clr = 1'b0;
    ready1 = 1'b0; ready0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    n_ferr = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    ps2_clk = 1'b1;
    repeat (HALF_BIT) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic bad_par);
    return {1'b1, ~(^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [7:0] code, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = make_frame(code, bad_par);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_bits(code, 1'b0, 11);
  endtask

  // Pop the event-mode head after checking it against the expected queue front.
  task automatic pop_ev(input string tag);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    check_val({tag, "_valid"}, e1_valid, 1'b1);
    check_val({tag, "_code"}, e1_code, exp);
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
  endtask

  task automatic pop_raw(input string tag);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    check_val({tag, "_valid"}, e0_valid, 1'b1);
    check_val({tag, "_code"}, e0_code, exp);
    check_val({tag, "_flags"}, {e0_ext, e0_brk}, 2'b00);
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; clr = 1'b0;
    ready1 = 1'b0; ready0 = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_valid", e1_valid, 1'b0);
    check_val("rst_level", e1_level, 3'd0);
    check_val("rst_code", {e1_ext, e1_brk, e1_code}, 10'h000);
    check_val("rst_err", {e1_ferr, e1_err, e1_ovf}, 10'h000);
    check_val("rst_state", e1_state, 2'd0);

    // 1: single make code
    do_reset();
    send_byte(8'h1C);
    check_val("t1_level", e1_level, 3'd1);
    check_val("t1_flags", {e1_ext, e1_brk}, 2'b00);
    check_val("t1_err", e1_err, 8'd0);
    exp_q.push_back(8'h1C);
    pop_ev("t1_pop");
    check_val("t1_empty", e1_valid, 1'b0);

    // 2: extended break folds into one event; raw mode keeps three bytes
    do_reset();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_val("t2_level", e1_level, 3'd1);
    check_val("t2_head", {e1_ext, e1_brk, e1_code}, {2'b11, 8'h75});
    check_val("t2_raw_level", e0_level, 3'd3);
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h75);
    pop_raw("t2_raw0");
    pop_raw("t2_raw1");
    pop_raw("t2_raw2");
    check_val("t2_raw_empty", e0_valid, 1'b0);

    // 3: bad parity rejected, next good byte accepted
    do_reset();
    send_bits(8'h1C, 1'b1, 11);
    check_val("t3_pulses", n_ferr, 1);
    check_val("t3_err", e1_err, 8'd1);
    check_val("t3_empty", e1_valid, 1'b0);
    send_byte(8'h1C);
    check_val("t3_level", e1_level, 3'd1);
    check_val("t3_code", e1_code, 8'h1C);
    check_val("t3_err2", e1_err, 8'd1);

    // 4: partial frame abandoned by timeout, not counted as an error
    do_reset();
    send_bits(8'h33, 1'b0, 5);
    repeat ((TIMEOUT + 50) * CLK_DIV) @(negedge clk);
    check_val("t4_idle", e1_state, 2'd0);
    send_byte(8'h5A);
    check_val("t4_level", e1_level, 3'd1);
    check_val("t4_code", e1_code, 8'h5A);
    check_val("t4_err", e1_err, 8'd0);
    check_val("t4_pulses", n_ferr, 0);

    // 5: overflow with consumer stalled, pop order, then clr
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h1B);
    send_byte(8'h23);
    send_byte(8'h2B);
    check_val("t5_ovf_before", e1_ovf, 1'b0);
    send_byte(8'h34);
    check_val("t5_level", e1_level, 3'd4);
    check_val("t5_ovf", e1_ovf, 1'b1);
    check_val("t5_head", e1_code, 8'h1C);
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h23);
    exp_q.push_back(8'h2B);
    pop_ev("t5_pop0");
    pop_ev("t5_pop1");
    pop_ev("t5_pop2");
    pop_ev("t5_pop3");
    check_val("t5_empty", {e1_valid, e1_level}, 4'h0);
    ready1 = 1'b1;  // ready while empty must not disturb anything
    repeat (3) @(negedge clk);
    ready1 = 1'b0;
    check_val("t5_empty_ready", e1_level, 3'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("t5_clr", e1_ovf, 1'b0);

    // 6: asynchronous reset mid-frame with entries queued
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h1B);
    check_val("t6_level_pre", e1_level, 3'd2);
    send_bits(8'h29, 1'b0, 5);
    ps2_clk = 1'b0;
    repeat (HALF_BIT / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("t6_valid", e1_valid, 1'b0);
    check_val("t6_level", e1_level, 3'd0);
    check_val("t6_code", {e1_ext, e1_brk, e1_code}, 10'h000);
    check_val("t6_state", e1_state, 2'd0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_byte(8'h29);
    check_val("t6_after_level", e1_level, 3'd1);
    check_val("t6_after_code", {e1_ext, e1_brk, e1_code}, {2'b00, 8'h29});
    check_val("t6_after_err", e1_err, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
